// File: rtl/instr_loader.sv
// Byte-stream instruction loader: assembles big-endian 16-bit words into instruction RAM
// and holds the CPU in reset until the image is complete. Define INSTR_LOADER_CHECKSUM_EN
// to require a trailing 16-bit checksum of the written words.
module instr_loader #(
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_din,
   output logic              mem_we,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int LW = ADDR_W + 1;

`ifdef INSTR_LOADER_CHECKSUM_EN
   typedef enum logic [3:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM_HI, S_CSUM_LO, S_DONE, S_ERROR
   } state_t;
`else
   typedef enum logic [3:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_DONE, S_ERROR
   } state_t;
`endif

   state_t            state_q, state_d;
   logic [7:0]        hi_q, hi_d;
   logic [LW-1:0]     len_q, len_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       din_q, din_d;
   logic              we_q, we_d;
   logic [LW-1:0]     cnt_q, cnt_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [15:0]       sum_q, sum_d;
`endif

   logic        readyC;
   logic        fire;
   logic        lastPending;
   logic [15:0] byteWord;

   // The write cycle of the final word closes the data phase; no byte is taken then.
   assign lastPending = we_q && ((cnt_q + LW'(1)) == len_q);
   assign byteWord    = {hi_q, in_data};
   assign fire        = in_valid && readyC;

   always_comb begin
      readyC = 1'b0;
      case (state_q)
         S_LEN_HI, S_LEN_LO, S_DATA_LO: readyC = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
         S_CSUM_HI, S_CSUM_LO:          readyC = 1'b1;
`endif
         S_DATA_HI:                     readyC = !lastPending;
         default:                       readyC = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      len_d   = len_q;
      addr_d  = addr_q;
      din_d   = din_q;
      we_d    = 1'b0;
      cnt_d   = cnt_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      // Bookkeeping for the word strobed this cycle; the address stays on the last word.
      if (we_q) begin
         cnt_d = cnt_q + LW'(1);
         if (!lastPending) addr_d = addr_q + ADDR_W'(1);
`ifdef INSTR_LOADER_CHECKSUM_EN
         sum_d = sum_q + din_q;
`endif
      end
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d = S_LEN_HI;
               addr_d  = '0;
               cnt_d   = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
               sum_d   = '0;
`endif
            end
         end
         S_LEN_HI: begin
            if (fire) begin
               hi_d    = in_data;
               state_d = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (fire) begin
               if (byteWord == 16'd0 || int'(byteWord) > DEPTH) begin
                  state_d = S_ERROR;
               end else begin
                  len_d   = LW'(byteWord);
                  state_d = S_DATA_HI;
               end
            end
         end
         S_DATA_HI: begin
            if (lastPending) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
               state_d = S_CSUM_HI;
`else
               state_d = S_DONE;
`endif
            end else if (fire) begin
               hi_d    = in_data;
               state_d = S_DATA_LO;
            end
         end
         S_DATA_LO: begin
            if (fire) begin
               din_d   = byteWord;
               we_d    = 1'b1;
               state_d = S_DATA_HI;
            end
         end
`ifdef INSTR_LOADER_CHECKSUM_EN
         S_CSUM_HI: begin
            if (fire) begin
               hi_d    = in_data;
               state_d = S_CSUM_LO;
            end
         end
         S_CSUM_LO: begin
            if (fire) state_d = (byteWord == sum_q) ? S_DONE : S_ERROR;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         hi_q    <= '0;
         len_q   <= '0;
         addr_q  <= '0;
         din_q   <= '0;
         we_q    <= 1'b0;
         cnt_q   <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         len_q   <= len_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         we_q    <= we_d;
         cnt_q   <= cnt_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

   assign in_ready     = readyC;
   assign mem_addr     = addr_q;
   assign mem_din      = din_q;
   assign mem_we       = we_q;
   assign words_loaded = cnt_q;
   assign done         = (state_q == S_DONE);
   assign error        = (state_q == S_ERROR);
   assign cpu_reset    = (state_q != S_DONE);
   assign busy         = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);

endmodule
